// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the PLL lock controller.
// State and decision encodings, plus the midscale code and PFD decision helpers.
package pll_ctrl_pkg;

    localparam int unsigned MAX_CODE_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COARSE = 2'd1,
        FINE   = 2'd2,
        LOCKED = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        INC  = 2'd1,
        DEC  = 2'd2
    } decision_t;

    // Midscale control word: only the MSB of a width-bit code set.
    function automatic logic [MAX_CODE_W-1:0] midscale(input int unsigned width);
        return MAX_CODE_W'(1) << (width - 1);
    endfunction

    // Both flags or neither means no usable phase information this slot.
    function automatic decision_t decide(input logic u, input logic d);
        if (u && !d) begin
            return INC;
        end
        if (d && !u) begin
            return DEC;
        end
        return HOLD;
    endfunction

endpackage

// File: rtl/pfd_flag_sync.sv
// Two-flop synchronizer for the asynchronous PFD up/down flags.
module pfd_flag_sync #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] flags,
    output logic [W-1:0] flags_s
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta    <= '0;
            flags_s <= '0;
        end else begin
            meta    <= flags;
            flags_s <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL lock controller: binary-search coarse acquisition, bang-bang fine tracking,
// and lock/unlock detection, driving the oscillator control word one slot at a time.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned CODE_W     = 8,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned LOCK_CNT   = 16,
    parameter int unsigned UNLOCK_CNT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              up,
    input  logic              dn,
    output logic [CODE_W-1:0] code,
    output logic              lock,
    output logic              busy,
    output logic [1:0]        state
);

    localparam int unsigned SLOT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned IDX_W  = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam int unsigned LCNT_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned UCNT_W = $clog2(UNLOCK_CNT + 1);

    localparam logic [CODE_W-1:0] CODE_MID = CODE_W'(midscale(CODE_W));
    localparam logic [CODE_W-1:0] CODE_MAX = '1;
    localparam logic [IDX_W-1:0]  BIT_TOP  = IDX_W'(CODE_W - 1);
    localparam logic [SLOT_W-1:0] SLOT_END = SLOT_W'(SETTLE_CYC - 1);

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                lock_q, lock_d;
    logic                busy_q, busy_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [IDX_W-1:0]    bit_q, bit_d;
    logic [LCNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [UCNT_W-1:0]   unl_cnt_q, unl_cnt_d;
    decision_t           prev_q, prev_d;

    logic [1:0]          flags_s;
    decision_t           dec;
    logic                slot_end;
    logic [SLOT_W-1:0]   slot_inc;
    logic                sat;
    logic                opposite;
    logic [CODE_W-1:0]   step_code;
    logic [LCNT_W-1:0]   lock_cnt_nxt;
    logic [UCNT_W-1:0]   unl_cnt_nxt;

    pfd_flag_sync #(
        .W (2)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .flags   ({up, dn}),
        .flags_s (flags_s)
    );

    // Slot timing and the bang-bang step shared by FINE and LOCKED.
    always_comb begin
        dec       = decide(flags_s[1], flags_s[0]);
        slot_end  = (slot_q == SLOT_END);
        slot_inc  = slot_end ? '0 : slot_q + SLOT_W'(1);
        sat       = ((dec == INC) && (code_q == CODE_MAX)) ||
                    ((dec == DEC) && (code_q == '0));
        opposite  = ((dec == INC) && (prev_q == DEC)) ||
                    ((dec == DEC) && (prev_q == INC));
        step_code = code_q;
        if (!sat) begin
            if (dec == INC) begin
                step_code = code_q + CODE_W'(1);
            end else if (dec == DEC) begin
                step_code = code_q - CODE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            code_q     <= CODE_MID;
            lock_q     <= 1'b0;
            busy_q     <= 1'b0;
            slot_q     <= '0;
            bit_q      <= '0;
            lock_cnt_q <= '0;
            unl_cnt_q  <= '0;
            prev_q     <= HOLD;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            lock_q     <= lock_d;
            busy_q     <= busy_d;
            slot_q     <= slot_d;
            bit_q      <= bit_d;
            lock_cnt_q <= lock_cnt_d;
            unl_cnt_q  <= unl_cnt_d;
            prev_q     <= prev_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        slot_d       = '0;
        bit_d        = bit_q;
        lock_cnt_d   = lock_cnt_q;
        unl_cnt_d    = unl_cnt_q;
        prev_d       = prev_q;
        lock_cnt_nxt = '0;
        unl_cnt_nxt  = '0;

        if (!en) begin
            // Abandon any slot in progress; code keeps its last value.
            state_d    = IDLE;
            prev_d     = HOLD;
            lock_cnt_d = '0;
            unl_cnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = COARSE;
                    code_d     = CODE_MID;
                    bit_d      = BIT_TOP;
                    lock_cnt_d = '0;
                    unl_cnt_d  = '0;
                end

                COARSE: begin
                    slot_d = slot_inc;
                    if (slot_end) begin
                        if (dec == DEC) begin
                            code_d[bit_q] = 1'b0;
                        end
                        if (bit_q != '0) begin
                            code_d[bit_q - IDX_W'(1)] = 1'b1;
                            bit_d = bit_q - IDX_W'(1);
                        end else begin
                            state_d    = FINE;
                            lock_cnt_d = '0;
                            prev_d     = HOLD;
                        end
                    end
                end

                FINE: begin
                    slot_d = slot_inc;
                    if (slot_end) begin
                        code_d = step_code;
                        if (dec != HOLD) begin
                            prev_d = dec;
                        end
                        // Small error: no usable direction, or a direction reversal.
                        if ((dec == HOLD) || (opposite && !sat)) begin
                            lock_cnt_nxt = lock_cnt_q + LCNT_W'(1);
                        end
                        lock_cnt_d = lock_cnt_nxt;
                        if (lock_cnt_nxt == LCNT_W'(LOCK_CNT)) begin
                            state_d   = LOCKED;
                            unl_cnt_d = '0;
                        end
                    end
                end

                LOCKED: begin
                    slot_d = slot_inc;
                    if (slot_end) begin
                        code_d = step_code;
                        if (dec != HOLD) begin
                            prev_d = dec;
                            if (dec == prev_q) begin
                                unl_cnt_nxt = unl_cnt_q + UCNT_W'(1);
                            end else begin
                                unl_cnt_nxt = UCNT_W'(1);
                            end
                        end
                        unl_cnt_d = unl_cnt_nxt;
                        if (unl_cnt_nxt == UCNT_W'(UNLOCK_CNT)) begin
                            state_d    = FINE;
                            lock_cnt_d = '0;
                            unl_cnt_d  = '0;
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        lock_d = (state_d == LOCKED);
        busy_d = (state_d == COARSE) || (state_d == FINE);
    end

    assign code  = code_q;
    assign lock  = lock_q;
    assign busy  = busy_q;
    assign state = state_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Scoreboard bench for pll_lock_ctrl: directed scenarios push cycle-stamped expected
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_pll_lock_ctrl;

    localparam int M_OFF = 0;
    localparam int M_TGT = 1;
    localparam int M_UP  = 2;
    localparam int M_DN  = 3;
    localparam int M_ALT = 4;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_COARSE = 2'd1;
    localparam logic [1:0] S_FINE   = 2'd2;
    localparam logic [1:0] S_LOCKED = 2'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       up;
    logic       dn;
    logic [7:0] code;
    logic       lock;
    logic       busy;
    logic [1:0] state;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  code;
        logic        lock;
        logic        busy;
        logic [1:0]  state;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          mode = M_OFF;
    logic [7:0]  tgt = 8'h5A;

    pll_lock_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .up    (up),
        .dn    (dn),
        .code  (code),
        .lock  (lock),
        .busy  (busy),
        .state (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural PFD: flags follow the current code relative to a target.
    always @(negedge clk) begin
        case (mode)
            M_TGT:   begin up = (code < tgt);  dn = (code > tgt); end
            M_UP:    begin up = 1'b1;          dn = 1'b0;         end
            M_DN:    begin up = 1'b0;          dn = 1'b1;         end
            M_ALT:   begin up = (code <= tgt); dn = (code > tgt); end
            default: begin up = 1'b0;          dn = 1'b0;         end
        endcase
    end

    // Monitor: compare every expectation due at this cycle.
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks = checks + 1;
            if (e.cyc != cyc || code !== e.code || lock !== e.lock ||
                busy !== e.busy || state !== e.state) begin
                errors = errors + 1;
                $display("FAIL %s @cyc %0d (due %0d): got code=%h lock=%b busy=%b state=%0d, want code=%h lock=%b busy=%b state=%0d",
                         e.name, cyc, e.cyc, code, lock, busy, state,
                         e.code, e.lock, e.busy, e.state);
            end
        end
    end

    task automatic push(input int unsigned c, input logic [7:0] cd,
                        input logic [1:0] st, input string nm);
        exp_t x;
        x.cyc   = c;
        x.code  = cd;
        x.state = st;
        x.lock  = (st == S_LOCKED);
        x.busy  = (st == S_COARSE) || (st == S_FINE);
        x.name  = nm;
        sb.push_back(x);
    endtask

    task automatic wait_cyc(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, %0d expectations pending", sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        up    = 1'b0;
        dn    = 1'b0;
        #2 reset = 1'b0;

        push(1, 8'h80, S_IDLE, "reset_state");
        wait_cyc(2);
        reset = 1'b1;
        push(4, 8'h80, S_IDLE, "idle_en_low");

        // Coarse with up forced, then async reset in the middle of it.
        wait_cyc(5);
        mode = M_UP;
        en   = 1'b1;
        push(6,  8'h80, S_COARSE, "coarse_entry");
        push(10, 8'hC0, S_COARSE, "coarse_bit7_keep");
        push(22, 8'hF8, S_COARSE, "coarse_mid");
        wait_cyc(24);
        @(posedge clk);
        #1 reset = 1'b0;
        en = 1'b0;
        #3 reset = 1'b1;
        push(25, 8'h80, S_IDLE, "async_reset");
        push(28, 8'h80, S_IDLE, "reset_idle_hold");

        // Full coarse with up forced, then saturated fine tracking.
        wait_cyc(29);
        en = 1'b1;
        push(58,  8'hFF, S_COARSE, "coarse_lsb_trial");
        push(62,  8'hFF, S_FINE,   "coarse_up_end");
        push(126, 8'hFF, S_FINE,   "fine_sat_nolock");
        push(142, 8'hFF, S_FINE,   "fine_sat_nolock2");

        // Disable holds code; re-enable with a 0x5A target and lock.
        wait_cyc(143);
        en   = 1'b0;
        mode = M_TGT;
        tgt  = 8'h5A;
        push(144, 8'hFF, S_IDLE, "disable_hold");
        wait_cyc(147);
        en = 1'b1;
        push(148, 8'h80, S_COARSE, "reenable_mid");
        push(152, 8'h40, S_COARSE, "coarse_bit7_clear");
        push(160, 8'h50, S_COARSE, "coarse_bit5_clear");
        push(172, 8'h5A, S_COARSE, "coarse_bit2");
        push(176, 8'h5B, S_COARSE, "coarse_hold_keep");
        push(180, 8'h5A, S_FINE,   "coarse_end_5a");
        push(243, 8'h5A, S_FINE,   "pre_lock");
        push(244, 8'h5A, S_LOCKED, "lock_at_96");

        // Four down decisions in LOCKED drop lock on the fourth.
        wait_cyc(244);
        mode = M_DN;
        push(248, 8'h59, S_LOCKED, "locked_dn1");
        push(256, 8'h57, S_LOCKED, "locked_dn3");
        push(260, 8'h56, S_FINE,   "unlock_dn4");

        // Walk back to target, relock after 16 holds.
        wait_cyc(260);
        mode = M_TGT;
        push(264, 8'h57, S_FINE,   "fine_inc1");
        push(276, 8'h5A, S_FINE,   "fine_back_5a");
        push(339, 8'h5A, S_FINE,   "relock_pre");
        push(340, 8'h5A, S_LOCKED, "relock");

        // Alternating up/dn keeps lock while the code dithers.
        wait_cyc(340);
        mode = M_ALT;
        for (int k = 0; k < 10; k++) begin
            push(344 + 4 * k, (k % 2 == 0) ? 8'h5B : 8'h5A, S_LOCKED, "locked_alt");
        end

        // Disable from LOCKED, acquire 0x41, disable in FINE, restart.
        wait_cyc(380);
        en   = 1'b0;
        mode = M_TGT;
        tgt  = 8'h41;
        push(381, 8'h5A, S_IDLE, "disable_locked");
        wait_cyc(383);
        en = 1'b1;
        push(388, 8'h40, S_COARSE, "coarse41_bit7");
        push(416, 8'h41, S_FINE,   "coarse_end_41");
        wait_cyc(420);
        en = 1'b0;
        push(421, 8'h41, S_IDLE, "disable_fine");
        push(424, 8'h41, S_IDLE, "idle_hold_41");
        wait_cyc(425);
        en = 1'b1;
        push(426, 8'h80, S_COARSE, "reenable_restart");

        wait_cyc(432);
        checks = checks + 1;
        if (state !== S_COARSE) begin
            errors = errors + 1;
            $display("FAIL final_state: got state=%0d, want %0d", state, S_COARSE);
        end
        checks = checks + 1;
        if (busy !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL final_busy: got busy=%b, want 1", busy);
        end
        checks = checks + 1;
        if (lock !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL final_lock: got lock=%b, want 0", lock);
        end
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s: expectation for cycle %0d never compared (now %0d)", e.name, e.cyc, cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pll_lock_ctrl.md
Name: pll_lock_ctrl

Overview:
Digital lock controller for the lab PLL. It closes the loop around the phase-frequency detector: it samples the PFD up/down flags once per update slot and steers the oscillator control word `code`. It runs a binary-search coarse acquisition, then a bang-bang fine-tracking loop, and asserts `lock` once phase error is bounded. It sits between the PFD flag outputs and the DCO/VCO tuning input, clocked by the reference clock.

Parameters:
CODE_W, 8, width of oscillator control word
SETTLE_CYC, 4, clk cycles per update slot; legal range is >= 3 so the 2-flop sync latency is covered
LOCK_CNT, 16, consecutive "small-error" fine updates required to declare lock
UNLOCK_CNT, 4, consecutive same-direction updates in LOCKED that drop lock

Ports:
clk  input  1  reference clock (PFD `in` clock)
reset  input  1  reset, asynchronous, active-low
en  input  1  loop enable, synchronous to clk
up  input  1  PFD up flag (ref leads fb); asynchronous, synchronized internally
dn  input  1  PFD down flag (fb leads ref); asynchronous, synchronized internally
code  output  CODE_W  oscillator control word, registered
lock  output  1  lock indication, registered
busy  output  1  high in COARSE or FINE
state  output  2  current state: IDLE=0, COARSE=1, FINE=2, LOCKED=3

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - code = 1<<(CODE_W-1) (0x80)
  - lock = 0, busy = 0, state = IDLE
  - all counters and sync flops = 0
- Synchronization: `up` and `dn` each pass through a 2-flop synchronizer, giving up_s and dn_s.
- Decision at the end of each slot:
  - INC when up_s=1 and dn_s=0
  - DEC when dn_s=1 and up_s=0
  - HOLD otherwise (neither flag, or both)
- Slot timing: a slot is exactly SETTLE_CYC cycles. The decision uses up_s/dn_s on the last cycle of the slot. The code update lands on that cycle's clock edge and the next slot starts the following cycle.
- IDLE:
  - code is held; lock = 0.
  - When en=1, go to COARSE, with code = 0x80 and bit index = CODE_W-1.
- COARSE: binary search, MSB to LSB, one bit per slot.
  - The trial bit is already set in code.
  - DEC clears the trial bit; INC or HOLD keeps it.
  - The next lower bit is then set as the new trial bit.
  - After the LSB decision, go to FINE with lock_cnt = 0.
  - Total duration = CODE_W*SETTLE_CYC cycles (32 at defaults).
- FINE: one bang-bang step per slot.
  - INC adds 1 and DEC subtracts 1, both saturating at 2^CODE_W-1 and 0. A saturated step holds the code.
  - lock_cnt increments when the decision is HOLD, or is opposite to the previous non-HOLD decision. Any other case, including a saturated step, clears lock_cnt.
  - When lock_cnt reaches LOCK_CNT: go to LOCKED; lock=1 on the same edge.
- LOCKED: stepping is the same as FINE.
  - unl_cnt counts consecutive same-direction decisions; HOLD or a reversal clears it.
  - When unl_cnt reaches UNLOCK_CNT: go to FINE, lock=0, lock_cnt=0.
- Disable: en=0 in any state goes to IDLE on the next edge. lock=0, code holds its last value, and an in-progress slot is abandoned.
  - Re-enable always restarts COARSE from 0x80.
- Previous-direction memory clears on entry to FINE from COARSE and on entry to IDLE.
- busy = (state==COARSE || state==FINE). lock == (state==LOCKED) at all times.

Decomposition:
- Package pll_ctrl_pkg holds:
  - state enum {IDLE, COARSE, FINE, LOCKED}
  - decision enum {HOLD, INC, DEC}
  - the midscale-code constant function
- Sub-module pfd_flag_sync: 2-flop synchronizer for up/dn with async active-low reset. It is instantiated once with a 2-bit width.

Test Plan:
- Reset mid-COARSE (reset low for 3 ns) -> code=0x80, lock=0, state=0 immediately. Nothing changes until en is seen high again.
- en=1, up held 1, dn=0 -> after 32 cycles, COARSE ends with code=0xFF. Then FINE saturates at 0xFF; lock_cnt stays 0 and lock never asserts.
- en=1, model target 0x5A (up when code<0x5A, dn when code>0x5A, neither when equal) -> COARSE ends at 0x5A. Then 16 HOLD slots give lock=1 at cycle 32+64.
- LOCKED, then dn forced high for 4 slots -> code decrements 4 times; lock falls on the 4th decision edge; state=FINE.
- LOCKED, alternating up/dn every slot -> code toggles between ±1 of its value and lock stays 1 indefinitely.
- en dropped in FINE at code=0x41 -> state IDLE next edge, code stays 0x41, busy=0. Re-raising en gives code=0x80, state=COARSE.
